prbs_pattern_gen: RTL

- Transmit-side pattern source for the noise tester.
- Drives a PRBS7 or PRBS9 bit stream into the channel under test for a programmed number of bits, at a programmed bit period.
- Outputs a clean reference bit, per-bit strobe and a test window; the receive-side XOR and error counter consume these. `window` drives the counter enable directly.
- Supports single-bit error injection for counter self-check.

---
 rtl/prbs_pkg.sv | 15 +
 rtl/prbs_lfsr.sv | 24 ++
 rtl/prbs_pattern_gen.sv | 82 ++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding, tap positions, seed and mode encodings for the PRBS source
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LFSR_W = 9;
  localparam logic MODE_PRBS7 = 1'b0;
  localparam logic MODE_PRBS9 = 1'b1;
  localparam int TAP7_A = 6;
  localparam int TAP7_B = 5;
  localparam int TAP9_A = 8;
  localparam int TAP9_B = 4;
  localparam logic [LFSR_W-1:0] SEED = '1;
  function automatic logic prbs_fb(input logic [LFSR_W-1:0] s, input logic m);
    return (m == MODE_PRBS9) ? s[TAP9_A] ^ s[TAP9_B] : s[TAP7_A] ^ s[TAP7_B];
  endfunction
endpackage

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: Fibonacci PRBS7/PRBS9 register; bit_out is the feedback that the next advance shifts in
module prbs_lfsr
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic load,
  input  logic advance,
  output logic bit_out
);
  logic [LFSR_W-1:0] s;
  logic [LFSR_W-1:0] cur;
  // a load in the same cycle as an advance emits the first bit of the fresh seed
  always_comb begin
    cur = load ? SEED : s;
    bit_out = prbs_fb(cur, mode);
  end
  // shift toward the MSB with the feedback entering at bit 0
  always_ff @(posedge clk)
    if (reset) s <= SEED;
    else if (advance) s <= {cur[LFSR_W-2:0], bit_out};
    else if (load) s <= SEED;
endmodule

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen: timed PRBS7/PRBS9 bit source with strobe, test window and single-bit error injection
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] bit_len,
  input  logic [DIV_W-1:0] period,
  input  logic             inject,
  output logic             tx_bit,
  output logic             ref_bit,
  output logic             bit_strobe,
  output logic             window,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic mode_q, pend, pend_n;
  logic [LEN_W-1:0] len_q, cnt, cnt_n;
  logic [DIV_W-1:0] per_q, div, div_n;
  logic accept, last, fin, adv, hold, lfsr_bit, tx_n, ref_n;
  prbs_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .mode   (state == IDLE ? mode : mode_q),
    .load   (accept),
    .advance(adv),
    .bit_out(lfsr_bit)
  );
  // next state: a bit boundary advances the LFSR; the boundary after the last bit ends the run
  always_comb begin
    accept = state == IDLE && start && bit_len != '0;
    last = state == RUN && div == per_q;
    fin = last && cnt == len_q;
    adv = accept || (last && !fin);
    hold = state == RUN && !last;
    state_n = accept ? RUN : fin ? DONE : state == RUN ? RUN : IDLE;
    div_n = hold ? div + DIV_W'(1) : '0;
    cnt_n = accept ? LEN_W'(1) : adv ? cnt + LEN_W'(1) : cnt;
    pend_n = hold && (pend || inject);
    ref_n = adv ? lfsr_bit : hold && ref_bit;
    tx_n = adv ? lfsr_bit ^ (last && (pend || inject)) : hold && tx_bit;
  end
  // state, counters, run parameters and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      div <= '0;
      cnt <= '0;
      pend <= 1'b0;
      mode_q <= 1'b0;
      len_q <= '0;
      per_q <= '0;
      tx_bit <= 1'b0;
      ref_bit <= 1'b0;
      bit_strobe <= 1'b0;
      window <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      cnt <= cnt_n;
      pend <= pend_n;
      if (accept) begin
        mode_q <= mode;
        len_q <= bit_len;
        per_q <= period;
      end
      tx_bit <= tx_n;
      ref_bit <= ref_n;
      bit_strobe <= adv;
      window <= state_n == RUN;
      busy <= state_n == RUN;
      done <= state_n == DONE;
    end
endmodule
